fwd_hazard_scoreboard: RTL and testbench
========================================

Name: fwd_hazard_scoreboard

Overview:
Next-generation operand-forwarding and hazard unit for the 5-stage RISC-V pipeline. It handles NUM_SRC source operands with a parametrised register-address width. Beyond EX/MEM and MEM/WB forwarding, it adds:
- load-use stall detection;
- a one-entry scoreboard that tracks a single outstanding multi-cycle (MUL/DIV) result;
- a saturating stall-cycle performance counter.

It sits beside the ID/EX boundary. It drives the EX operand muxes and the PC/IF-ID write-enables and bubble insertion.

Parameters:
NUM_SRC, 2, number of source operands per instruction (1..4)
REG_AW, 5, register address width
MAX_LAT, 8, maximum multi-cycle latency in cycles (>=1)
LAT_W, $clog2(MAX_LAT+1), width of latency field (derived)
CNT_W, 32, width of stall performance counter

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
ex_rs_i  in  NUM_SRC*REG_AW  ID/EX source addresses, source k at [k*REG_AW +: REG_AW]
ex_mem_regwrite_i  in  1  EX/MEM writes a register
ex_mem_rd_i  in  REG_AW  EX/MEM destination
mem_wb_regwrite_i  in  1  MEM/WB writes a register
mem_wb_rd_i  in  REG_AW  MEM/WB destination
id_rs_i  in  NUM_SRC*REG_AW  IF/ID source addresses
id_rs_valid_i  in  NUM_SRC  IF/ID source k is actually read
id_mc_i  in  1  IF/ID instruction is a multi-cycle op
id_ex_memread_i  in  1  ID/EX instruction is a load
id_ex_rd_i  in  REG_AW  ID/EX destination
mc_issue_i  in  1  multi-cycle op leaves ID/EX into the MC unit this cycle
mc_rd_i  in  REG_AW  destination of issuing MC op
mc_lat_i  in  LAT_W  latency of issuing MC op
flush_i  in  1  branch flush; cancels this cycle's issue
fwd_sel_o  out  NUM_SRC*2  per-source mux select
stall_o  out  1  hold PC and IF/ID
bubble_o  out  1  insert NOP into ID/EX
mc_busy_o  out  1  scoreboard entry valid
mc_done_o  out  1  one-cycle pulse on last pending cycle
stall_cnt_o  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst_n_i low, asynchronous): scoreboard invalid, counter 0, stall_cnt_o 0. All outputs are 0 while in reset.
- Forwarding (combinational) for each source k:
  - 2'b10 if ex_mem_regwrite_i && ex_mem_rd_i!=0 && ex_mem_rd_i==rs_k;
  - else 2'b01 if mem_wb_regwrite_i && mem_wb_rd_i!=0 && mem_wb_rd_i==rs_k;
  - else 2'b00.
  - EX/MEM always wins over MEM/WB. 2'b11 is never driven.
- Load-use hazard: id_ex_memread_i && id_ex_rd_i!=0 && any valid id source == id_ex_rd_i.
- Scoreboard registers: sb_valid, sb_rd, sb_cnt[LAT_W].
  - On issue (mc_issue_i && !flush_i && mc_lat_i!=0 && !sb_valid): sb_valid=1, sb_rd=mc_rd_i, sb_cnt=mc_lat_i.
  - mc_lat_i==0 is illegal. The issue is ignored.
  - An issue while sb_valid is ignored; the stall rule below makes it unreachable.
  - While sb_valid: sb_cnt decrements each cycle.
  - When sb_cnt==1: mc_done_o=1 and sb_valid clears at the next edge.
  - Issue at edge t with latency L: mc_busy_o is high for exactly L cycles and mc_done_o pulses in the L-th.
- MC hazard:
  - RAW: sb_valid && sb_rd!=0 && any valid id source == sb_rd && !(sb_cnt==1).
  - Structural: id_mc_i && sb_valid && !(sb_cnt==1).
  - In the done cycle the result is on the MEM/WB path, so no stall is needed.
- stall_o = bubble_o = load-use || MC hazard. Both are combinational from inputs and registered state.
- stall_cnt_o increments on every cycle with stall_o=1. It saturates at all-ones and never wraps.
- flush_i does not clear an already-valid scoreboard entry; an in-flight MC op completes.
- Simultaneous done and new issue in the same cycle: the new entry is loaded (sb_valid is treated as free when sb_cnt==1).
- Reset asserted mid-operation drops the pending entry immediately.

Decomposition:
- Shared package fwd_pkg:
  - FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10 constants;
  - the fwd_sel_t 2-bit typedef.
- One sub-module, fwd_src_select: per-source combinational forward priority logic, instantiated NUM_SRC times with a generate loop.
- Scoreboard, hazard logic and counter stay in the top module.

Test Plan:
- ex_mem_regwrite=1, ex_mem_rd=5, mem_wb_regwrite=1, mem_wb_rd=5, ex_rs0=5, ex_rs1=5 -> fwd_sel_o=4'b1010. Repeat with mem_wb_rd=6, ex_rs1=6 -> 4'b0110. Repeat with rd=0 -> 4'b0000.
- id_ex_memread=1, id_ex_rd=7, id_rs1=7 valid -> stall_o=bubble_o=1 for one cycle. Same with id_rs_valid[1]=0 -> no stall.
- Issue MC rd=9 lat=4 at cycle t, id_rs0=9 valid held -> mc_busy_o high t+1..t+4; stall_o high t+1..t+3; mc_done_o at t+4; stall_cnt_o=3.
- MC busy (lat=3) with id_mc_i=1 -> structural stall until the done cycle. In the done cycle mc_issue_i lat=2 loads a new entry: busy stays continuous for 2 further cycles.
- mc_issue_i with flush_i=1, or with mc_lat_i=0 -> mc_busy_o stays 0.
- Assert rst_n_i low mid-countdown (async, between edges) -> mc_busy_o, stall_o and stall_cnt_o drop to 0 immediately. Force the counter near all-ones (CNT_W=4 build) -> holds at 4'hF.

Source files
------------

// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the operand-forwarding / hazard unit.
//   fwd_sel_t  : 2-bit EX operand mux select
//   FWD_NONE   : operand comes from the register file (ID/EX latch)
//   FWD_MEM_WB : operand forwarded from the MEM/WB result
//   FWD_EX_MEM : operand forwarded from the EX/MEM result
// The encoding 2'b11 is never produced.
// -----------------------------------------------------------------------------
package fwd_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_NONE   = 2'b00;
    localparam fwd_sel_t FWD_MEM_WB = 2'b01;
    localparam fwd_sel_t FWD_EX_MEM = 2'b10;

endpackage : fwd_pkg

// File: rtl/fwd_src_select.sv
// -----------------------------------------------------------------------------
// fwd_src_select
// Forward-priority decision for a single EX source operand.
// Ports:
//   rs              in  REG_AW  source register address in ID/EX
//   ex_mem_regwrite in  1       EX/MEM stage writes a register
//   ex_mem_rd       in  REG_AW  EX/MEM destination register
//   mem_wb_regwrite in  1       MEM/WB stage writes a register
//   mem_wb_rd       in  REG_AW  MEM/WB destination register
//   sel             out 2       mux select (fwd_sel_t)
// The younger EX/MEM result always wins over MEM/WB; x0 never forwards.
// -----------------------------------------------------------------------------
module fwd_src_select
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              ex_mem_regwrite,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              mem_wb_regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    output fwd_sel_t          sel
);

    logic ex_mem_hit;
    logic mem_wb_hit;

    assign ex_mem_hit = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs);
    assign mem_wb_hit = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs);

    always_comb begin
        // NOTE: every path through a combinational block must assign every
        // output, so a default comes first; otherwise a latch is inferred.
        sel = FWD_NONE;
        if (ex_mem_hit) begin
            sel = FWD_EX_MEM;
        end else if (mem_wb_hit) begin
            sel = FWD_MEM_WB;
        end
    end

endmodule : fwd_src_select

// File: rtl/fwd_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_hazard_scoreboard
// Operand forwarding and hazard detection for the 5-stage pipeline, sitting
// beside the ID/EX boundary.
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   ex_rs_i                 ID/EX source addresses, source k at [k*REG_AW +: REG_AW]
//   ex_mem_regwrite_i/_rd_i EX/MEM writeback info
//   mem_wb_regwrite_i/_rd_i MEM/WB writeback info
//   id_rs_i, id_rs_valid_i  IF/ID source addresses and read-enables
//   id_mc_i                 IF/ID instruction is a multi-cycle op
//   id_ex_memread_i/_rd_i   ID/EX instruction is a load, and its destination
//   mc_issue_i/_rd_i/_lat_i multi-cycle op leaving ID/EX into the MC unit
//   flush_i                 branch flush, cancels this cycle's MC issue
//   fwd_sel_o               per-source EX mux select (2 bits per source)
//   stall_o, bubble_o       hold PC/IF-ID and insert a NOP into ID/EX
//   mc_busy_o, mc_done_o    scoreboard entry valid / last pending cycle
//   stall_cnt_o             saturating count of stalled cycles
// All outputs read 0 while rst_n_i is low.
// -----------------------------------------------------------------------------
module fwd_hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int MAX_LAT = 8,
    parameter int LAT_W   = $clog2(MAX_LAT + 1),
    parameter int CNT_W   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
    input  logic                      ex_mem_regwrite_i,
    input  logic [REG_AW-1:0]         ex_mem_rd_i,
    input  logic                      mem_wb_regwrite_i,
    input  logic [REG_AW-1:0]         mem_wb_rd_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
    input  logic [NUM_SRC-1:0]        id_rs_valid_i,
    input  logic                      id_mc_i,
    input  logic                      id_ex_memread_i,
    input  logic [REG_AW-1:0]         id_ex_rd_i,
    input  logic                      mc_issue_i,
    input  logic [REG_AW-1:0]         mc_rd_i,
    input  logic [LAT_W-1:0]          mc_lat_i,
    input  logic                      flush_i,
    output logic [NUM_SRC*2-1:0]      fwd_sel_o,
    output logic                      stall_o,
    output logic                      bubble_o,
    output logic                      mc_busy_o,
    output logic                      mc_done_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    // ---------------- forwarding ----------------
    logic [NUM_SRC*2-1:0] fwd_sel;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_src_select #(.REG_AW(REG_AW)) u_sel (
            .rs              (ex_rs_i[k*REG_AW +: REG_AW]),
            .ex_mem_regwrite (ex_mem_regwrite_i),
            .ex_mem_rd       (ex_mem_rd_i),
            .mem_wb_regwrite (mem_wb_regwrite_i),
            .mem_wb_rd       (mem_wb_rd_i),
            .sel             (fwd_sel[k*2 +: 2])
        );
    end

    // Combinational outputs are masked so the whole block reads 0 in reset.
    assign fwd_sel_o = rst_n_i ? fwd_sel : '0;

    // ---------------- scoreboard ----------------
    logic              sb_valid;
    logic [REG_AW-1:0] sb_rd;
    logic [LAT_W-1:0]  sb_cnt;
    logic              sb_last;
    logic              sb_free;
    logic              issue_ok;

    assign sb_last  = sb_valid && (sb_cnt == LAT_W'(1));
    // The entry in its done cycle retires at this edge, so it may be replaced.
    assign sb_free  = !sb_valid || sb_last;
    assign issue_ok = mc_issue_i && !flush_i && (mc_lat_i != '0) && sb_free;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            sb_valid <= 1'b0;
            sb_rd    <= '0;
            sb_cnt   <= '0;
        end else if (issue_ok) begin
            sb_valid <= 1'b1;
            sb_rd    <= mc_rd_i;
            sb_cnt   <= mc_lat_i;
        end else if (sb_valid) begin
            sb_cnt <= sb_cnt - LAT_W'(1);
            if (sb_last) begin
                sb_valid <= 1'b0;
            end
        end
    end

    assign mc_busy_o = sb_valid;
    assign mc_done_o = sb_last;

    // ---------------- hazards ----------------
    logic load_use_match;
    logic sb_match;
    logic load_use;
    logic mc_raw;
    logic mc_struct;
    logic hazard;

    always_comb begin
        load_use_match = 1'b0;
        sb_match       = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_rs_valid_i[k] && (id_rs_i[k*REG_AW +: REG_AW] == id_ex_rd_i)) begin
                load_use_match = 1'b1;
            end
            if (id_rs_valid_i[k] && (id_rs_i[k*REG_AW +: REG_AW] == sb_rd)) begin
                sb_match = 1'b1;
            end
        end
    end

    assign load_use  = id_ex_memread_i && (id_ex_rd_i != '0) && load_use_match;
    // In the done cycle the MC result is already on the MEM/WB path.
    assign mc_raw    = sb_valid && (sb_rd != '0) && sb_match && !sb_last;
    assign mc_struct = id_mc_i && sb_valid && !sb_last;
    assign hazard    = load_use || mc_raw || mc_struct;

    assign stall_o  = rst_n_i && hazard;
    assign bubble_o = stall_o;

    // ---------------- stall performance counter ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
        end else if (hazard && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule : fwd_hazard_scoreboard

// File: tb/tb_fwd_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_scoreboard
// Directed-vector bench. The driver applies one vector per cycle and queues
// the hand-computed expected outputs; a monitor pops and compares them on the
// falling edge. A second instance with CNT_W=4 shares the stimulus so counter
// saturation is exercised.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int REG_AW  = 5;
    localparam int LAT_W   = 4;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_SRC*REG_AW-1:0] ex_rs;
    logic                      ex_mem_regwrite;
    logic [REG_AW-1:0]         ex_mem_rd;
    logic                      mem_wb_regwrite;
    logic [REG_AW-1:0]         mem_wb_rd;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_valid;
    logic                      id_mc;
    logic                      id_ex_memread;
    logic [REG_AW-1:0]         id_ex_rd;
    logic                      mc_issue;
    logic [REG_AW-1:0]         mc_rd;
    logic [LAT_W-1:0]          mc_lat;
    logic                      flush;

    logic [NUM_SRC*2-1:0] fwd_sel, fwd_sel4;
    logic                 stall, stall4, bubble, bubble4;
    logic                 busy, busy4, done, done4;
    logic [31:0]          stall_cnt;
    logic [3:0]           stall_cnt4;

    always #5 clk = ~clk;

    fwd_hazard_scoreboard #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .MAX_LAT(8), .CNT_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ex_rs_i(ex_rs),
        .ex_mem_regwrite_i(ex_mem_regwrite), .ex_mem_rd_i(ex_mem_rd),
        .mem_wb_regwrite_i(mem_wb_regwrite), .mem_wb_rd_i(mem_wb_rd),
        .id_rs_i(id_rs), .id_rs_valid_i(id_rs_valid), .id_mc_i(id_mc),
        .id_ex_memread_i(id_ex_memread), .id_ex_rd_i(id_ex_rd),
        .mc_issue_i(mc_issue), .mc_rd_i(mc_rd), .mc_lat_i(mc_lat), .flush_i(flush),
        .fwd_sel_o(fwd_sel), .stall_o(stall), .bubble_o(bubble),
        .mc_busy_o(busy), .mc_done_o(done), .stall_cnt_o(stall_cnt)
    );

    fwd_hazard_scoreboard #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .MAX_LAT(8), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .ex_rs_i(ex_rs),
        .ex_mem_regwrite_i(ex_mem_regwrite), .ex_mem_rd_i(ex_mem_rd),
        .mem_wb_regwrite_i(mem_wb_regwrite), .mem_wb_rd_i(mem_wb_rd),
        .id_rs_i(id_rs), .id_rs_valid_i(id_rs_valid), .id_mc_i(id_mc),
        .id_ex_memread_i(id_ex_memread), .id_ex_rd_i(id_ex_rd),
        .mc_issue_i(mc_issue), .mc_rd_i(mc_rd), .mc_lat_i(mc_lat), .flush_i(flush),
        .fwd_sel_o(fwd_sel4), .stall_o(stall4), .bubble_o(bubble4),
        .mc_busy_o(busy4), .mc_done_o(done4), .stall_cnt_o(stall_cnt4)
    );

    typedef struct {
        string       name;
        logic [3:0]  fwd;
        logic        stall;
        logic        busy;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Queue the expectation for the current vector, then advance one cycle.
    task automatic step(input string name, input logic [3:0] fwd, input logic stl,
                        input logic bsy, input logic dn);
        exp_t e;
        e.name  = name;
        e.fwd   = fwd;
        e.stall = stl;
        e.busy  = bsy;
        e.done  = dn;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (stl && rst_n) exp_cnt++;
    endtask

    task automatic clear_inputs();
        ex_rs = '0; ex_mem_regwrite = 1'b0; ex_mem_rd = '0;
        mem_wb_regwrite = 1'b0; mem_wb_rd = '0;
        id_rs = '0; id_rs_valid = '0; id_mc = 1'b0;
        id_ex_memread = 1'b0; id_ex_rd = '0;
        mc_issue = 1'b0; mc_rd = '0; mc_lat = '0; flush = 1'b0;
    endtask

    // Monitor: compares whatever the driver queued for this cycle.
    initial begin
        exp_t        e;
        logic [31:0] c4;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                c4 = (e.cnt > 32'd15) ? 32'd15 : e.cnt;
                check({e.name, ".fwd_sel"},    32'(fwd_sel),    32'(e.fwd));
                check({e.name, ".stall"},      32'(stall),      32'(e.stall));
                check({e.name, ".bubble"},     32'(bubble),     32'(e.stall));
                check({e.name, ".mc_busy"},    32'(busy),       32'(e.busy));
                check({e.name, ".mc_done"},    32'(done),       32'(e.done));
                check({e.name, ".stall_cnt"},  stall_cnt,       e.cnt);
                check({e.name, ".fwd_sel4"},   32'(fwd_sel4),   32'(e.fwd));
                check({e.name, ".stall4"},     32'(stall4),     32'(e.stall));
                check({e.name, ".bubble4"},    32'(bubble4),    32'(e.stall));
                check({e.name, ".mc_busy4"},   32'(busy4),      32'(e.busy));
                check({e.name, ".mc_done4"},   32'(done4),      32'(e.done));
                check({e.name, ".stall_cnt4"}, 32'(stall_cnt4), c4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Driver
    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        // In reset, a forwarding match must still read as 0.
        ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5; ex_rs = {5'd5, 5'd5};
        step("in_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        rst_n = 1'b1;

        // Forwarding
        ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5;
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd5;
        ex_rs = {5'd5, 5'd5};
        step("fwd_both_exmem", 4'b1010, 1'b0, 1'b0, 1'b0);
        mem_wb_rd = 5'd6; ex_rs = {5'd6, 5'd5};
        step("fwd_mix", 4'b0110, 1'b0, 1'b0, 1'b0);
        ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; ex_rs = {5'd0, 5'd0};
        step("fwd_x0", 4'b0000, 1'b0, 1'b0, 1'b0);
        ex_mem_regwrite = 1'b0; ex_mem_rd = 5'd5; mem_wb_rd = 5'd5;
        ex_rs = {5'd3, 5'd5};
        step("fwd_memwb_only", 4'b0001, 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // Load-use
        id_ex_memread = 1'b1; id_ex_rd = 5'd7;
        id_rs = {5'd7, 5'd2}; id_rs_valid = 2'b11;
        step("load_use", 4'b0000, 1'b1, 1'b0, 1'b0);
        id_rs_valid = 2'b01;
        step("load_use_invalid", 4'b0000, 1'b0, 1'b0, 1'b0);
        id_ex_rd = 5'd0; id_rs = '0; id_rs_valid = 2'b11;
        step("load_use_x0", 4'b0000, 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // MC RAW: lat=4 on r9, consumer reads r9
        mc_issue = 1'b1; mc_rd = 5'd9; mc_lat = 4'd4;
        id_rs = {5'd0, 5'd9}; id_rs_valid = 2'b01;
        step("raw_issue", 4'b0000, 1'b0, 1'b0, 1'b0);
        mc_issue = 1'b0;
        step("raw_c1", 4'b0000, 1'b1, 1'b1, 1'b0);
        step("raw_c2", 4'b0000, 1'b1, 1'b1, 1'b0);
        step("raw_c3", 4'b0000, 1'b1, 1'b1, 1'b0);
        step("raw_done", 4'b0000, 1'b0, 1'b1, 1'b1);
        step("raw_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // Structural: lat=3 with an MC op waiting in ID, back-to-back issue
        mc_issue = 1'b1; mc_rd = 5'd10; mc_lat = 4'd3; id_mc = 1'b1;
        step("st_issue", 4'b0000, 1'b0, 1'b0, 1'b0);
        mc_issue = 1'b0;
        step("st_c1", 4'b0000, 1'b1, 1'b1, 1'b0);
        step("st_c2", 4'b0000, 1'b1, 1'b1, 1'b0);
        mc_issue = 1'b1; mc_rd = 5'd11; mc_lat = 4'd2;
        step("st_done_reissue", 4'b0000, 1'b0, 1'b1, 1'b1);
        mc_issue = 1'b0;
        step("st_next_c1", 4'b0000, 1'b1, 1'b1, 1'b0);
        step("st_next_done", 4'b0000, 1'b0, 1'b1, 1'b1);
        id_mc = 1'b0;
        step("st_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // Cancelled issues
        mc_issue = 1'b1; mc_rd = 5'd3; mc_lat = 4'd3; flush = 1'b1;
        step("flush_issue", 4'b0000, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        step("flush_after", 4'b0000, 1'b0, 1'b0, 1'b0);
        mc_issue = 1'b1; mc_rd = 5'd3; mc_lat = 4'd0;
        step("lat0_issue", 4'b0000, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        step("lat0_after", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Counter: 7 stalls so far; 12 more pass the 4-bit limit
        id_ex_memread = 1'b1; id_ex_rd = 5'd7;
        id_rs = {5'd7, 5'd0}; id_rs_valid = 2'b10;
        for (int i = 0; i < 12; i++) begin
            step("sat_stall", 4'b0000, 1'b1, 1'b0, 1'b0);
        end
        clear_inputs();
        step("sat_hold", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Async reset in the middle of a countdown
        mc_issue = 1'b1; mc_rd = 5'd12; mc_lat = 4'd5;
        id_rs = {5'd0, 5'd12}; id_rs_valid = 2'b01;
        step("rst_issue", 4'b0000, 1'b0, 1'b0, 1'b0);
        mc_issue = 1'b0;
        step("rst_busy", 4'b0000, 1'b1, 1'b1, 1'b0);
        // Between edges: drop reset while a load-use and a forward match are live.
        id_ex_memread = 1'b1; id_ex_rd = 5'd12;
        ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5; ex_rs = {5'd0, 5'd5};
        rst_n = 1'b0;
        exp_cnt = '0;
        step("rst_async", 4'b0000, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        rst_n = 1'b1;
        step("rst_release", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Bounded drain of the expectation queue
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fwd_hazard_scoreboard
